// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the EX stage; results land in HI/LO.
// Optional MULDIV_EARLY_OUT_EN: multiply leaves CALC once the remaining multiplier bits are zero.
module ex_muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

    state_t             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               dbz_q, dbz_d;
    logic [W2-1:0]      acc_q, acc_d;
    logic [W2-1:0]      mc_q, mc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, dbz_o_q, dbz_o_d, busy_q, busy_d;

    logic               a_neg, b_neg, last_step;
    logic [WIDTH-1:0]   a_abs, b_abs, quo, rem;
    logic [WIDTH:0]     rem_sh, diff;
    logic [W2-1:0]      mul_sum, prod;

    always_comb begin
        a_neg   = ~op[0] & src_a[WIDTH-1];
        b_neg   = ~op[0] & src_b[WIDTH-1];
        a_abs   = a_neg ? (WIDTH'(0) - src_a) : src_a;
        b_abs   = b_neg ? (WIDTH'(0) - src_b) : src_b;
        // acc holds {remainder, dividend/quotient} during divide
        rem_sh  = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, mq_q};
        mul_sum = acc_q + (mq_q[0] ? mc_q : W2'(0));
        quo     = neg_lo_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem     = neg_hi_q ? (WIDTH'(0) - acc_q[W2-1:WIDTH]) : acc_q[W2-1:WIDTH];
        prod    = neg_lo_q ? (W2'(0) - acc_q) : acc_q;
`ifdef MULDIV_EARLY_OUT_EN
        last_step = (cnt_q == CNT_W'(WIDTH - 1)) || (!is_div_q && (mq_q[WIDTH-1:1] == '0));
`else
        last_step = (cnt_q == CNT_W'(WIDTH - 1));
`endif
    end

    // Next-state and datapath updates
    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dbz_d    = dbz_q;
        acc_d    = acc_q;
        mc_d     = mc_q;
        mq_d     = mq_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_o_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    is_div_d = op[1];
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = op[1] ? a_neg : (a_neg ^ b_neg);
                    dbz_d    = op[1] && (src_b == '0);
                    cnt_d    = '0;
                    mq_d     = b_abs;
                    acc_d    = op[1] ? {WIDTH'(0), a_abs} : W2'(0);
                    // divide keeps the raw dividend for the divide-by-zero HI value
                    mc_d     = op[1] ? {WIDTH'(0), src_a} : {WIDTH'(0), a_abs};
                    state_d  = (op[1] && (src_b == '0)) ? FIXUP : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_div_q) begin
                        acc_d = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                            : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = mul_sum;
                        mc_d  = mc_q << 1;
                        mq_d  = mq_q >> 1;
                    end
                    if (last_step) state_d = FIXUP;
                end
            end
            FIXUP: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (dbz_q) begin
                        hi_d    = mc_q[WIDTH-1:0];
                        lo_d    = '1;
                        dbz_o_d = 1'b1;
                    end else if (is_div_q) begin
                        hi_d = rem;
                        lo_d = quo;
                    end else begin
                        hi_d = prod[W2-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dbz_q    <= 1'b0;
            acc_q    <= '0;
            mc_q     <= '0;
            mq_q     <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_o_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dbz_q    <= dbz_d;
            acc_q    <= acc_d;
            mc_q     <= mc_d;
            mq_q     <= mq_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_o_q  <= dbz_o_d;
            busy_q   <= busy_d;
        end
    end

    assign stall       = ((state_q == IDLE) && start && !flush) || busy_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_o_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
